// File: rtl/mp2_cache.sv
//------------------------------------------------------------------------------
// Module   : mp2_cache
// Brief    : Direct-mapped, write-back, write-allocate cache, 8 x 128-bit lines.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mp2_cache (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [15:0]  mem_wdata,
   input  logic [1:0]   mem_byte_enable,
   output logic [15:0]  mem_rdata,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   typedef enum logic [1:0] {
      CHECK     = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2
   } state_t;

   state_t r_state, w_next_state;

   logic [127:0] r_data [8];
   logic [8:0]   r_tag  [8];
   logic [7:0]   r_valid;
   logic [7:0]   r_dirty;

   logic [2:0]   w_index;
   logic [8:0]   w_tag;
   logic [2:0]   w_word;
   logic [127:0] w_line;
   logic [15:0]  w_old_word;
   logic [15:0]  w_new_word;
   logic         w_req;
   logic         w_hit;
   logic         w_write_hit;
   logic         w_fill_done;
   logic         w_unused;

   assign w_index    = mem_address[6:4];
   assign w_tag      = mem_address[15:7];
   assign w_word     = mem_address[3:1];
   assign w_unused   = mem_address[0];
   assign w_line     = r_data[w_index];
   assign w_old_word = w_line[{w_word, 4'b0000} +: 16];
   assign w_new_word = {mem_byte_enable[1] ? mem_wdata[15:8] : w_old_word[15:8],
                        mem_byte_enable[0] ? mem_wdata[7:0]  : w_old_word[7:0]};

   assign w_req       = mem_read | mem_write;
   assign w_hit       = w_req & r_valid[w_index] & (r_tag[w_index] == w_tag);
   // A simultaneous read and write is handled as a write.
   assign w_write_hit = (r_state == CHECK) & w_hit & mem_write;
   assign w_fill_done = (r_state == FILL) & pmem_resp;

   assign mem_rdata  = w_old_word;
   assign pmem_wdata = w_line;

   always_comb begin
      w_next_state = r_state;
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = {mem_address[15:4], 4'b0000};
      case (r_state)
         CHECK: begin
            if (w_hit) begin
               mem_resp = 1'b1;
            end else if (w_req) begin
               w_next_state = (r_valid[w_index] & r_dirty[w_index]) ? WRITEBACK : FILL;
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {r_tag[w_index], w_index, 4'b0000};
            if (pmem_resp) w_next_state = FILL;
         end
         FILL: begin
            pmem_read = 1'b1;
            if (pmem_resp) w_next_state = CHECK;
         end
         default: w_next_state = CHECK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CHECK;
         r_valid <= 8'h00;
         r_dirty <= 8'h00;
      end else begin
         r_state <= w_next_state;
         if (w_fill_done) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
         end else if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
         end
      end
   end

   // Data and tag arrays carry no reset; a reset edge only suppresses updates.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_fill_done) begin
            r_data[w_index] <= pmem_rdata;
            r_tag[w_index]  <= w_tag;
         end else if (w_write_hit) begin
            r_data[w_index][{w_word, 4'b0000} +: 16] <= w_new_word;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mp2_cache.sv
//------------------------------------------------------------------------------
// Module   : tb_mp2_cache
// Brief    : Directed self-checking bench for mp2_cache with a 3-cycle memory.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mp2_cache;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read;
   logic         mem_write;
   logic [15:0]  mem_address;
   logic [15:0]  mem_wdata;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   int total = 0;
   int bad   = 0;

   // memory model state
   logic         mem_en;
   int           lat_cnt   = 0;
   int           wb_count  = 0;
   int           fill_count = 0;
   int           wr_cycles = 0;
   int           both_high = 0;
   logic [15:0]  wb_addr;
   logic [127:0] wb_data;
   logic [15:0]  fill_addr;

   always #5 clk = ~clk;

   mp2_cache dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   // Fill word k of a line is (line address - 0x10) + k.
   always_comb begin
      pmem_rdata = '0;
      for (int k = 0; k < 8; k++)
         pmem_rdata[16*k +: 16] = (pmem_address - 16'h0010) + 16'(k);
   end

   // Physical memory answers on the third cycle of each request.
   initial pmem_resp = 1'b0;
   always @(negedge clk) begin
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) both_high++;
      if (pmem_write) wr_cycles++;
      if (mem_en && (pmem_read || pmem_write)) begin
         lat_cnt++;
         if (lat_cnt == 3) begin
            pmem_resp = 1'b1;
            lat_cnt   = 0;
            if (pmem_write) begin
               wb_count++;
               wb_addr = pmem_address;
               wb_data = pmem_wdata;
            end else begin
               fill_count++;
               fill_addr = pmem_address;
            end
         end
      end else begin
         lat_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be,
                         output logic [15:0] rdata, output int cycles);
      bit done;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; mem_address = addr;
      mem_wdata = wdata; mem_byte_enable = be;
      cycles = 0; done = 0; rdata = 'x;
      while (!done && cycles < 50) begin
         @(negedge clk);
         cycles++;
         if (mem_resp) begin
            done  = 1;
            rdata = mem_rdata;
         end
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      if (!done) check("timeout", 0, 1);
   endtask

   logic [15:0] rd;
   int          cyc;
   int          snap;

   initial begin
      rst = 1'b1; mem_en = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
      mem_wdata = '0; mem_byte_enable = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mem_resp", mem_resp, 0);
      check("rst_pmem_read", pmem_read, 0);
      check("rst_pmem_write", pmem_write, 0);

      // cold miss then hit on the same line
      access(1, 0, 16'h0010, 16'h0, 2'b00, rd, cyc);
      check("fill_rdata", rd, 16'h0000);
      check("fill_latency", cyc, 5);
      check("fill_addr", fill_addr, 16'h0010);
      check("fill_count", fill_count, 1);
      access(1, 0, 16'h001E, 16'h0, 2'b00, rd, cyc);
      check("hit_rdata", rd, 16'h0007);
      check("hit_latency", cyc, 1);

      // low-byte write hit
      access(0, 1, 16'h0012, 16'hBEEF, 2'b01, rd, cyc);
      check("wr_hit_latency", cyc, 1);
      access(1, 0, 16'h0012, 16'h0, 2'b00, rd, cyc);
      check("wr_merge", rd, 16'h00EF);
      check("wr_no_pmem", wb_count + fill_count, 1);

      // conflict miss on dirty line
      access(1, 0, 16'h0090, 16'h0, 2'b00, rd, cyc);
      check("wb_latency", cyc, 8);
      check("wb_count", wb_count, 1);
      check("wb_addr", wb_addr, 16'h0010);
      check("wb_data", wb_data,
            128'h0007_0006_0005_0004_0003_0002_00EF_0000);
      check("wb_fill_addr", fill_addr, 16'h0090);
      check("wb_rdata", rd, 16'h0080);

      // conflict miss on clean line
      snap = wr_cycles;
      access(1, 0, 16'h0110, 16'h0, 2'b00, rd, cyc);
      check("clean_latency", cyc, 5);
      check("clean_no_write", wr_cycles, snap);
      check("clean_rdata", rd, 16'h0100);

      // empty byte mask still dirties the line
      access(0, 1, 16'h0114, 16'hFFFF, 2'b00, rd, cyc);
      check("be0_latency", cyc, 1);
      access(1, 0, 16'h0114, 16'h0, 2'b00, rd, cyc);
      check("be0_unchanged", rd, 16'h0102);
      access(1, 0, 16'h0010, 16'h0, 2'b00, rd, cyc);
      check("be0_wb_count", wb_count, 2);
      check("be0_wb_addr", wb_addr, 16'h0110);
      check("be0_rdata", rd, 16'h0000);

      // read and write together act as a write
      access(1, 1, 16'h0016, 16'h1234, 2'b11, rd, cyc);
      check("rw_latency", cyc, 1);
      @(negedge clk);
      check("rw_resp_single", mem_resp, 0);
      access(1, 0, 16'h0016, 16'h0, 2'b00, rd, cyc);
      check("rw_written", rd, 16'h1234);

      // reset aborts a pending fill
      @(posedge clk); #1;
      mem_en = 1'b0; mem_read = 1'b1; mem_address = 16'h0230;
      repeat (3) @(negedge clk);
      check("abort_fill_req", pmem_read, 1);
      @(posedge clk); #1;
      rst = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; mem_en = 1'b1;
      @(negedge clk);
      check("abort_pmem_read", pmem_read, 0);
      check("abort_pmem_write", pmem_write, 0);
      snap = fill_count;
      access(1, 0, 16'h0230, 16'h0, 2'b00, rd, cyc);
      check("reissue_latency", cyc, 5);
      check("reissue_fill", fill_count, snap + 1);
      check("reissue_rdata", rd, 16'h0220);
      access(1, 0, 16'h0016, 16'h0, 2'b00, rd, cyc);
      check("post_rst_miss", cyc, 5);

      check("pmem_exclusive", both_high, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mp2_cache.md
MP2_CACHE -- requirements
Module: mp2_cache

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 mem_read  input  1  CPU read request; held high until mem_resp.
REQ-004 mem_write  input  1  CPU write request; held high until mem_resp.
REQ-005 mem_address  input  16  CPU byte address (lc3b_word); bits [3:0] offset, [6:4] index, [15:7] tag.
REQ-006 mem_wdata  input  16  CPU write data (lc3b_word).
REQ-007 mem_byte_enable  input  2  write byte mask (lc3b_mem_wmask); bit0 = low byte, bit1 = high byte.
REQ-008 mem_rdata  output  16  word at mem_address[3:1] of the addressed line.
REQ-009 mem_resp  output  1  one-cycle completion pulse to CPU.
REQ-010 pmem_read  output  1  physical-memory line read request.
REQ-011 pmem_write  output  1  physical-memory line write request.
REQ-012 pmem_address  output  16  line address; bits [3:0] always 0.
REQ-013 pmem_wdata  output  128  evicted line data.
REQ-014 pmem_rdata  input  128  fill line data; valid when pmem_resp is high.
REQ-015 pmem_resp  input  1  physical-memory completion, one cycle.

Function
REQ-016 Organisation SHALL be direct-mapped, write-back, write-allocate: 8 lines x 128 bits, with 9-bit tag, valid and dirty bits per line.
REQ-017 FSM states SHALL be CHECK, WRITEBACK and FILL.
REQ-018 CHECK SHALL define hit as (mem_read | mem_write) & valid[index] & (tag[index] == mem_address[15:7]).
REQ-019 On a read hit in CHECK, mem_resp SHALL be 1 combinationally in the same cycle and mem_rdata SHALL equal the line word at offset[3:1] (word k occupies bits [16k+15:16k]).
REQ-020 On a write hit in CHECK, mem_resp SHALL be 1 combinationally; at the next edge, bytes selected by mem_byte_enable SHALL merge into word offset[3:1] and dirty[index] SHALL be set to 1.
REQ-021 A write with mem_byte_enable = 2'b00 SHALL respond, change no data, and still set dirty.
REQ-022 On a miss in CHECK with valid & dirty, the FSM SHALL move to WRITEBACK; otherwise it SHALL move to FILL; mem_resp SHALL be 0 on a miss.
REQ-023 In WRITEBACK: pmem_write = 1, pmem_address = {tag[index], index, 4'b0}, pmem_wdata = line[index], all held stable until pmem_resp; on pmem_resp the FSM SHALL go to FILL.
REQ-024 In FILL: pmem_read = 1, pmem_address = {mem_address[15:4], 4'b0}, held until pmem_resp; on pmem_resp the line SHALL load pmem_rdata, tag, valid = 1 and dirty = 0, and the FSM SHALL go to CHECK.
REQ-025 After FILL, the returning CHECK cycle SHALL hit and complete the request; miss latency = 1 + (WB cycles) + (FILL cycles) + 1.
REQ-026 pmem_read and pmem_write SHALL never be high together; both SHALL be 0 in CHECK.
REQ-027 pmem_resp SHALL be ignored in CHECK.
REQ-028 If mem_read and mem_write are both high, the request SHALL be treated as a write.
REQ-029 With no request in CHECK, there SHALL be no state change and mem_resp = 0.
REQ-030 mem_resp SHALL never be high outside CHECK.

Reset
REQ-031 When rst = 1 at an edge: state = CHECK, all valid = 0, all dirty = 0.
REQ-032 Outputs after reset: mem_resp = 0, pmem_read = 0, pmem_write = 0; the data and tag arrays are not reset.
REQ-033 A reset during WRITEBACK or FILL SHALL abort the transfer; pmem_read/pmem_write SHALL be 0 in the following cycle, and no line update SHALL occur.

Verification
REQ-034 Reset, read 0x0010, pmem returns 128'h...0007_0006_0005_0004_0003_0002_0001_0000 after 3 cycles -> one FILL at pmem_address 0x0010, then mem_resp with mem_rdata 0x0000; reading 0x001E then hits in 1 cycle with 0x0007.
REQ-035 Write 0xBEEF to 0x0012 with byte_enable 2'b01 after the line above is filled -> hit, word1 = 0x00EF, dirty set, no pmem activity.
REQ-036 Read 0x0090 (same index, tag 1) after REQ-035 -> WRITEBACK to 0x0010 with word1 = 0x00EF, then FILL at 0x0090, then mem_resp.
REQ-037 Miss to a clean line -> FILL only, with pmem_write never asserted.
REQ-038 Assert rst during FILL with pmem_resp withheld -> pmem_read = 0 next cycle; the re-issued read misses.
REQ-039 mem_read and mem_write both high on a hit -> write performed, mem_resp = 1 for one cycle.
